udp_payload_framer: RTL

Read-side consumer of the UDP packetizer ring buffer, in the Ethernet (`rclk`) domain. It watches the buffer fill level and, once a full payload is stored, drains exactly `PAYLOAD_LEN` bytes from the buffer. It emits them as one framed byte stream: 4-byte header, payload, and an optional 1-byte trailer. The stream uses a valid/ready/last handshake toward the UDP/IP header inserter and MAC.

---
 rtl/udp_payload_framer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/udp_payload_framer.sv
`timescale 1ns/1ps
// Ring-buffer read-side framer: drains PAYLOAD_LEN bytes and emits header + payload on a valid/ready stream.
// Optional XOR trailer beat is built only when FRAMER_TRAILER_EN is defined.
module udp_payload_framer #(
    parameter int unsigned PAYLOAD_LEN = 256,
    parameter int unsigned FILL_W      = 11
) (
    input  logic              rclk,
    input  logic              rst_n,
    input  logic [FILL_W-1:0] fill_counter,
    output logic              rd_en,
    input  logic              rd_valid,
    input  logic [7:0]        rd_data,
    output logic [7:0]        m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic [15:0]       seq
);
    localparam logic [FILL_W-1:0] LEN_C  = FILL_W'(PAYLOAD_LEN);
    localparam logic [FILL_W-1:0] LAST_C = FILL_W'(PAYLOAD_LEN - 1);
    localparam logic [15:0]       LEN16  = 16'(PAYLOAD_LEN);

    typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;
    state_t state, state_next;

    logic [1:0]        beat;
    logic [FILL_W-1:0] issued;
    logic [FILL_W-1:0] sent;
    logic              in_flight;
    logic [7:0]        skid0;
    logic [7:0]        skid1;
    logic [1:0]        skid_cnt;
    logic [1:0]        occ;
    logic              push;
    logic              pop;
`ifdef FRAMER_TRAILER_EN
    logic [7:0]        xor_acc;
`endif

    assign pop  = (state == PAY) && m_tvalid && m_tready;
    assign push = rd_valid && in_flight;
    assign busy = (state != IDLE);

    // The slot freed by this cycle's pop counts as free, so a held-ready stream has no bubbles.
    assign occ   = skid_cnt - {1'b0, pop} + {1'b0, in_flight};
    assign rd_en = ((state == HDR) || (state == PAY)) && (issued < LEN_C) && (occ < 2'd2);

    always_comb begin
        state_next = state;
        m_tvalid   = 1'b0;
        m_tdata    = '0;
        m_tlast    = 1'b0;
        case (state)
            IDLE: begin
                if (fill_counter >= LEN_C) state_next = HDR;
            end
            HDR: begin
                m_tvalid = 1'b1;
                case (beat)
                    2'd0:    m_tdata = seq[15:8];
                    2'd1:    m_tdata = seq[7:0];
                    2'd2:    m_tdata = LEN16[15:8];
                    default: m_tdata = LEN16[7:0];
                endcase
                if (m_tready && (beat == 2'd3)) state_next = PAY;
            end
            PAY: begin
                m_tvalid = (skid_cnt != 2'd0);
                m_tdata  = skid0;
`ifdef FRAMER_TRAILER_EN
                if (m_tvalid && m_tready && (sent == LAST_C)) state_next = TRL;
`else
                m_tlast = m_tvalid && (sent == LAST_C);
                if (m_tvalid && m_tready && (sent == LAST_C)) state_next = IDLE;
`endif
            end
`ifdef FRAMER_TRAILER_EN
            TRL: begin
                m_tvalid = 1'b1;
                m_tdata  = xor_acc;
                m_tlast  = 1'b1;
                if (m_tready) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            seq       <= '0;
            beat      <= '0;
            issued    <= '0;
            sent      <= '0;
            in_flight <= 1'b0;
            skid0     <= '0;
            skid1     <= '0;
            skid_cnt  <= '0;
        end else begin
            state     <= state_next;
            in_flight <= rd_en;
            if (state == IDLE) begin
                beat   <= '0;
                issued <= '0;
                sent   <= '0;
            end else begin
                if (rd_en) issued <= issued + FILL_W'(1);
                if ((state == HDR) && m_tready) beat <= beat + 2'd1;
                if (pop) sent <= sent + FILL_W'(1);
            end
            if (m_tvalid && m_tready && m_tlast) seq <= seq + 16'd1;
            case ({push, pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) skid0 <= rd_data;
                    else                  skid1 <= rd_data;
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid0 <= rd_data;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FRAMER_TRAILER_EN
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n)             xor_acc <= '0;
        else if (state == IDLE) xor_acc <= '0;
        else if (pop)           xor_acc <= xor_acc ^ skid0;
    end
`endif

endmodule
